uart_rx_oversample: RTL

//  UART receiver driven by the 16x baud tick from the baud clock generator (baud_clock).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 36 +++
 rtl/uart_rx_oversample.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling tick positions.
// The transmitter uses the same package.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [3:0] SAMP_CHK = 4'd7;
    localparam logic [3:0] SAMP_MID = 4'd9;
    localparam logic [3:0] SAMP_END = 4'd15;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the serial input plus a 3-tick majority voter.
// The voter samples the line at ticks SAMP_MID-2 and SAMP_MID-1 and resolves at SAMP_MID.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit RX_IDLE_VAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_clock_i,
    input  logic       rx_i,
    input  logic [3:0] samp_cnt_i,
    output logic       rx_s_o,
    output logic       maj_bit_o
);
    import uart_pkg::*;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             vote_q;

    // NOTE: the chain resets to the idle level so that leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RX_IDLE_VAL}};
            vote_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            if (baud_clock_i && samp_cnt_i == SAMP_MID - 4'd2) vote_q[0] <= rx_s_o;
            if (baud_clock_i && samp_cnt_i == SAMP_MID - 4'd1) vote_q[1] <= rx_s_o;
        end
    end

    // Normalise so downstream logic always sees 1 = idle/mark.
    assign rx_s_o    = RX_IDLE_VAL ? sync_q[SYNC_STAGES-1] : ~sync_q[SYNC_STAGES-1];
    assign maj_bit_o = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_o) | (vote_q[1] & rx_s_o);

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver: start-bit qualification, mid-bit majority sampling,
// 7/8-bit LSB-first frames with optional parity, and host-facing byte/error registers.
module uart_rx_oversample #(
    parameter int SYNC_STAGES = 2,
    parameter bit RX_IDLE_VAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);
    import uart_pkg::*;

    rx_state_t  state_q, state_d;
    logic [3:0] samp_cnt_q, samp_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       pbit_q, pbit_d;
    logic       armed_q, armed_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_ready_q, rx_ready_d;
    logic       parity_err_q, parity_err_d;
    logic       framing_err_q, framing_err_d;
    logic       overflow_q, overflow_d;

    logic       rx_s, maj_bit;
    logic       shift_en, pbit_en, commit;
    logic [2:0] last_bit;
    logic [7:0] frame_data;
    logic       perr;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RX_IDLE_VAL (RX_IDLE_VAL)
    ) u_sync (
        .clk          (clk),
        .reset        (reset),
        .baud_clock_i (baud_clock),
        .rx_i         (rx),
        .samp_cnt_i   (samp_cnt_q),
        .rx_s_o       (rx_s),
        .maj_bit_o    (maj_bit)
    );

    assign last_bit   = bit8 ? 3'd7 : 3'd6;
    // In 7-bit mode the frame sits in shreg[7:1]; shreg[0] is stale from the previous frame.
    assign frame_data = bit8 ? shreg_q : {1'b0, shreg_q[7:1]};
    assign perr       = ((^frame_data) ^ pbit_q) != odd_n_even;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (baud_clock) begin
            case (state_q)
                IDLE:    if (armed_q && !rx_s) state_d = START;
                START:   if (samp_cnt_q == SAMP_CHK && rx_s) state_d = IDLE;
                         else if (samp_cnt_q == SAMP_END)    state_d = DATA;
                DATA:    if (samp_cnt_q == SAMP_END && bit_cnt_q == last_bit)
                             state_d = parity_en ? PARITY : STOP;
                PARITY:  if (samp_cnt_q == SAMP_END) state_d = STOP;
                STOP:    if (samp_cnt_q == SAMP_MID) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_en = baud_clock && state_q == DATA   && samp_cnt_q == SAMP_MID;
        pbit_en  = baud_clock && state_q == PARITY && samp_cnt_q == SAMP_MID;
        commit   = baud_clock && state_q == STOP   && samp_cnt_q == SAMP_MID;
    end

    always_comb begin
        samp_cnt_d    = samp_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        pbit_d        = pbit_q;
        armed_d       = armed_q;
        rx_byte_d     = rx_byte_q;
        rx_ready_d    = rx_ready_q;
        parity_err_d  = parity_err_q;
        framing_err_d = framing_err_q;
        overflow_d    = overflow_q;

        if (baud_clock) begin
            if (state_q == IDLE) begin
                // A low stop bit disarms start detection until the line returns to idle.
                if (rx_s)         armed_d    = 1'b1;
                else if (armed_q) samp_cnt_d = '0;
            end else begin
                samp_cnt_d = samp_cnt_q + 4'd1;
            end
            if (state_q == START && samp_cnt_q == SAMP_END) bit_cnt_d = '0;
            if (state_q == DATA  && samp_cnt_q == SAMP_END) bit_cnt_d = bit_cnt_q + 3'd1;
        end

        if (shift_en) shreg_d = {maj_bit, shreg_q[7:1]};
        if (pbit_en)  pbit_d  = maj_bit;

        if (read_rx_byte && rx_ready_q) begin
            rx_ready_d = 1'b0;
            overflow_d = 1'b0;
        end
        if (commit) begin
            rx_byte_d     = frame_data;
            framing_err_d = ~maj_bit;
            parity_err_d  = perr & parity_en;
            rx_ready_d    = 1'b1;
            armed_d       = maj_bit;
            if (rx_ready_q && !read_rx_byte) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            samp_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            pbit_q        <= 1'b0;
            armed_q       <= 1'b1;
            rx_byte_q     <= '0;
            rx_ready_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            samp_cnt_q    <= samp_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            pbit_q        <= pbit_d;
            armed_q       <= armed_d;
            rx_byte_q     <= rx_byte_d;
            rx_ready_q    <= rx_ready_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            overflow_q    <= overflow_d;
        end
    end

    assign rx_byte     = rx_byte_q;
    assign rx_ready    = rx_ready_q;
    assign parity_err  = parity_err_q;
    assign framing_err = framing_err_q;
    assign overflow    = overflow_q;

endmodule
